// File: rtl/dispatch_unit_param_if.sv
// dispatch_unit_param_if
// Bundles every non-clock/reset signal of the dispatch stage.
//   ifetch side   : ifetch_pc_4, ifetch_intruction, ifetch_empty (in);
//                   Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr (out)
//   register file : regfile_rs_addr/rt_addr (out), regfile_rs_data/rt_data (in)
//   CDB snoop     : cdb_valid, cdb_tag, cdb_data (in)
//   issue queues  : dispatch_* payload and dispatch_en_* (out),
//                   issueque_*_full (in)
//   debug         : dbg_state (out), current FSM state (0 = RUN, 1 = FLUSH)
// Handshake: the dispatch stage pops the ifetch head exactly on a rising
// clock edge where Dispatch_ren = 1; an issue queue accepts the payload on
// an edge where its dispatch_en_* = 1, which is only raised while that
// queue's full flag is low. No other signal implies a transfer.
// modport master = dispatch stage, modport slave = its environment.
interface dispatch_unit_param_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int TAG_W  = 5
);
  logic [31:0]       ifetch_pc_4;
  logic [31:0]       ifetch_intruction;
  logic              ifetch_empty;
  logic              Dispatch_ren;
  logic              Dispatch_jmp;
  logic [31:0]       Dispatch_jmp_addr;
  logic [REG_AW-1:0] regfile_rs_addr;
  logic [REG_AW-1:0] regfile_rt_addr;
  logic [DATA_W-1:0] regfile_rs_data;
  logic [DATA_W-1:0] regfile_rt_data;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [DATA_W-1:0] dispatch_rs_data;
  logic [DATA_W-1:0] dispatch_rt_data;
  logic              dispatch_rs_data_valid;
  logic              dispatch_rt_data_valid;
  logic [TAG_W-1:0]  dispatch_rs_tag;
  logic [TAG_W-1:0]  dispatch_rt_tag;
  logic [TAG_W-1:0]  dispatch_rd_tag;
  logic [3:0]        dispatch_opcode;
  logic [4:0]        dispatch_shfamt;
  logic [15:0]       dispatch_imm_ld_st;
  logic              dispatch_en_integer;
  logic              dispatch_en_ld_st;
  logic              dispatch_en_mul;
  logic              issueque_integer_full;
  logic              issueque_full_ld_st;
  logic              issueque_mul_full;
  logic [0:0]        dbg_state;

  modport master (
    input  ifetch_pc_4, ifetch_intruction, ifetch_empty,
    output Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr,
    output regfile_rs_addr, regfile_rt_addr,
    input  regfile_rs_data, regfile_rt_data,
    input  cdb_valid, cdb_tag, cdb_data,
    output dispatch_rs_data, dispatch_rt_data,
    output dispatch_rs_data_valid, dispatch_rt_data_valid,
    output dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag,
    output dispatch_opcode, dispatch_shfamt, dispatch_imm_ld_st,
    output dispatch_en_integer, dispatch_en_ld_st, dispatch_en_mul,
    input  issueque_integer_full, issueque_full_ld_st, issueque_mul_full,
    output dbg_state
  );

  modport slave (
    output ifetch_pc_4, ifetch_intruction, ifetch_empty,
    input  Dispatch_ren, Dispatch_jmp, Dispatch_jmp_addr,
    input  regfile_rs_addr, regfile_rt_addr,
    output regfile_rs_data, regfile_rt_data,
    output cdb_valid, cdb_tag, cdb_data,
    input  dispatch_rs_data, dispatch_rt_data,
    input  dispatch_rs_data_valid, dispatch_rt_data_valid,
    input  dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag,
    input  dispatch_opcode, dispatch_shfamt, dispatch_imm_ld_st,
    input  dispatch_en_integer, dispatch_en_ld_st, dispatch_en_mul,
    output issueque_integer_full, issueque_full_ld_st, issueque_mul_full,
    input  dbg_state
  );
endinterface

// File: rtl/dispatch_unit_param.sv
// dispatch_unit_param
// In-order dispatch stage of the Tomasulo MIPS core. Each cycle it decodes
// the ifetch head, resolves operands through the register status table
// (RST), allocates a result tag from a round-robin tag pool, and writes the
// instruction into the integer, load/store or multiply issue queue. J-type
// jumps redirect ifetch and spend one FLUSH cycle. The CDB is snooped to
// free tags and clear RST entries.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   dp     dispatch_unit_param_if.master (ifetch, regfile, CDB, issue
//          queue signals and the FSM debug state)
// Optional feature macro: CDB_BYPASS_EN
//   defined   : a busy operand whose producer is on the CDB this cycle is
//               forwarded from cdb_data.
//   undefined : that case stalls dispatch for one cycle; the instruction
//               goes out next cycle with the operand read from the regfile.
module dispatch_unit_param #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int TAG_W  = 5
) (
  input logic clock,
  input logic reset,
  dispatch_unit_param_if.master dp
);
  localparam int NREG = 1 << REG_AW;
  localparam int NTAG = 1 << TAG_W;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [TAG_W-1:0]  alloc_q, alloc_d;
  logic [NTAG-1:0]   tag_free_q, tag_free_d;
  logic [NREG-1:0]   rst_busy_q, rst_busy_d;
  logic [TAG_W-1:0]  rst_tag_q [NREG];
  logic [TAG_W-1:0]  rst_tag_d [NREG];

  // ---------------- decode ----------------
  logic [31:0] instr;
  logic [5:0]  op6, funct;
  logic        is_int, is_mul, is_lw, is_sw, is_jump, is_ldst;
  logic        needs_tag, unsup, has_dest;
  logic [3:0]  opc;
  logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr, dest;

  assign instr   = dp.ifetch_intruction;
  assign op6     = instr[31:26];
  assign funct   = instr[5:0];
  assign rs_addr = REG_AW'(instr[25:21]);
  assign rt_addr = REG_AW'(instr[20:16]);
  assign rd_addr = REG_AW'(instr[15:11]);

  // Jumps and unsupported encodings report opcode 0; no queue sees them.
  always_comb begin
    is_int  = 1'b0;
    is_mul  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_jump = 1'b0;
    opc     = 4'h0;
    case (op6)
      6'h00: begin
        case (funct)
          6'h20: begin is_int = 1'b1; opc = 4'h0; end
          6'h22: begin is_int = 1'b1; opc = 4'h1; end
          6'h24: begin is_int = 1'b1; opc = 4'h2; end
          6'h25: begin is_int = 1'b1; opc = 4'h3; end
          6'h2A: begin is_int = 1'b1; opc = 4'h4; end
          6'h00: begin is_int = 1'b1; opc = 4'h5; end
          6'h02: begin is_int = 1'b1; opc = 4'h6; end
          6'h19: begin is_mul = 1'b1; opc = 4'hA; end
          default: ;
        endcase
      end
      6'h23:   begin is_lw = 1'b1; opc = 4'h8; end
      6'h2B:   begin is_sw = 1'b1; opc = 4'h9; end
      6'h02:   is_jump = 1'b1;
      default: ;
    endcase
  end

  assign is_ldst   = is_lw | is_sw;
  assign needs_tag = is_int | is_ldst | is_mul;
  assign unsup     = !needs_tag && !is_jump;
  assign has_dest  = is_int | is_mul | is_lw;
  assign dest      = is_lw ? rt_addr : rd_addr;

  // ---------------- operand resolution ----------------
  logic              rs_busy, rt_busy, rs_hit, rt_hit;
  logic [TAG_W-1:0]  rs_cur_tag, rt_cur_tag;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              rs_valid, rt_valid;
  logic [TAG_W-1:0]  rs_tag, rt_tag;

  assign rs_busy    = rst_busy_q[rs_addr];
  assign rt_busy    = rst_busy_q[rt_addr];
  assign rs_cur_tag = rst_tag_q[rs_addr];
  assign rt_cur_tag = rst_tag_q[rt_addr];
  // Register 0 is never marked busy, so no hit is possible on it.
  assign rs_hit = rs_busy && dp.cdb_valid && (dp.cdb_tag == rs_cur_tag);
  assign rt_hit = rt_busy && dp.cdb_valid && (dp.cdb_tag == rt_cur_tag);

  always_comb begin
    rs_data  = '0;
    rs_valid = 1'b1;
    rs_tag   = '0;
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (!rs_busy) begin
      rs_data = dp.regfile_rs_data;
`ifdef CDB_BYPASS_EN
    end else if (rs_hit) begin
      rs_data = dp.cdb_data;
`endif
    end else begin
      rs_valid = 1'b0;
      rs_tag   = rs_cur_tag;
    end
  end

  always_comb begin
    rt_data  = '0;
    rt_valid = 1'b1;
    rt_tag   = '0;
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (!rt_busy) begin
      rt_data = dp.regfile_rt_data;
`ifdef CDB_BYPASS_EN
    end else if (rt_hit) begin
      rt_data = dp.cdb_data;
`endif
    end else begin
      rt_valid = 1'b0;
      rt_tag   = rt_cur_tag;
    end
  end

  // ---------------- dispatch decision ----------------
  logic target_full, cdb_stall, ren;

  assign target_full = (is_int  && dp.issueque_integer_full) ||
                       (is_ldst && dp.issueque_full_ld_st)   ||
                       (is_mul  && dp.issueque_mul_full);
`ifdef CDB_BYPASS_EN
  assign cdb_stall = 1'b0;
`else
  // Without forwarding, wait one cycle for the RST clear to land.
  assign cdb_stall = needs_tag && (rs_hit || rt_hit);
`endif

  assign ren = !reset && (state_q == ST_RUN) && !dp.ifetch_empty &&
               !target_full && !cdb_stall &&
               (is_jump || unsup || tag_free_q[alloc_q]);

  // ---------------- next state ----------------
  always_comb begin
    state_d    = state_q;
    alloc_d    = alloc_q;
    tag_free_d = tag_free_q;
    rst_busy_d = rst_busy_q;
    rst_tag_d  = rst_tag_q;
    if (dp.cdb_valid) begin
      tag_free_d[dp.cdb_tag] = 1'b1;
      for (int r = 0; r < NREG; r++) begin
        if (rst_busy_q[r] && (rst_tag_q[r] == dp.cdb_tag)) rst_busy_d[r] = 1'b0;
      end
    end
    case (state_q)
      ST_RUN:   if (ren && is_jump) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    // Applied after the CDB clear so a same-cycle RST write wins.
    if (ren && needs_tag) begin
      tag_free_d[alloc_q] = 1'b0;
      alloc_d = (alloc_q == TAG_W'(NTAG - 1)) ? TAG_W'(1) : alloc_q + TAG_W'(1);
      if (has_dest && (dest != '0)) begin
        rst_busy_d[dest] = 1'b1;
        rst_tag_d[dest]  = alloc_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      alloc_q    <= TAG_W'(1);
      tag_free_q <= '1;
      rst_busy_q <= '0;
      for (int r = 0; r < NREG; r++) rst_tag_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      alloc_q    <= alloc_d;
      tag_free_q <= tag_free_d;
      rst_busy_q <= rst_busy_d;
      rst_tag_q  <= rst_tag_d;
    end
  end

  // ---------------- outputs ----------------
  assign dp.Dispatch_ren           = ren;
  assign dp.Dispatch_jmp           = ren && is_jump;
  assign dp.Dispatch_jmp_addr      = {dp.ifetch_pc_4[31:28], instr[25:0], 2'b00};
  assign dp.regfile_rs_addr        = rs_addr;
  assign dp.regfile_rt_addr        = rt_addr;
  assign dp.dispatch_rs_data       = rs_data;
  assign dp.dispatch_rt_data       = rt_data;
  assign dp.dispatch_rs_data_valid = rs_valid;
  assign dp.dispatch_rt_data_valid = rt_valid;
  assign dp.dispatch_rs_tag        = rs_tag;
  assign dp.dispatch_rt_tag        = rt_tag;
  assign dp.dispatch_rd_tag        = alloc_q;
  assign dp.dispatch_opcode        = opc;
  assign dp.dispatch_shfamt        = instr[10:6];
  assign dp.dispatch_imm_ld_st     = instr[15:0];
  assign dp.dispatch_en_integer    = ren && is_int;
  assign dp.dispatch_en_ld_st      = ren && is_ldst;
  assign dp.dispatch_en_mul        = ren && is_mul;
  assign dp.dbg_state              = state_q;

  // Low PC bits only matter to the fetch stage.
  logic unused_ok;
`ifdef CDB_BYPASS_EN
  assign unused_ok = ^{dp.ifetch_pc_4[27:0]};
`else
  assign unused_ok = ^{dp.ifetch_pc_4[27:0], dp.cdb_data};
`endif
endmodule

// File: tb/tb_dispatch_unit_param.sv
// tb_dispatch_unit_param
// Bench for dispatch_unit_param. Register file model: register i reads as i.
// Every sampled cycle pushes the expected output record into exp_q when the
// stimulus is applied and pops it against the DUT outputs at the falling
// edge. Build with +define+CDB_BYPASS_EN to cover the forwarding variant.
module tb_dispatch_unit_param;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int TAG_W  = 5;

  localparam int K_INT = 0, K_LS = 1, K_MUL = 2, K_J = 3, K_NONE = 4;

  typedef struct packed {
    logic              ren;
    logic              jmp;
    logic              en_i;
    logic              en_l;
    logic              en_m;
    logic [3:0]        op;
    logic [TAG_W-1:0]  rd_tag;
    logic              rs_v;
    logic [TAG_W-1:0]  rs_t;
    logic [DATA_W-1:0] rs_d;
    logic              rt_v;
    logic [TAG_W-1:0]  rt_t;
    logic [DATA_W-1:0] rt_d;
    logic [4:0]        sh;
    logic [15:0]       imm;
    logic [31:0]       ja;
  } rec_t;
  localparam int REC_W = $bits(rec_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_unit_param_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TAG_W(TAG_W)) dp ();

  dispatch_unit_param #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TAG_W(TAG_W)) dut (
    .clock (clk),
    .reset (rst),
    .dp    (dp.master)
  );

  assign dp.regfile_rs_data = DATA_W'(dp.regfile_rs_addr);
  assign dp.regfile_rt_data = DATA_W'(dp.regfile_rt_addr);

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got, e;
  int n_total = 0;
  int n_bad   = 0;

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd,
                                         input int sh, input logic [5:0] fn);
    logic [4:0] a, b, c, s;
    a = 5'(rs); b = 5'(rt); c = 5'(rd); s = 5'(sh);
    return {6'h00, a, b, c, s, fn};
  endfunction

  function automatic logic [REC_W-1:0] mk(
    input logic ren, input int kind, input logic [3:0] op, input int rdt,
    input logic rsv, input int rst_, input int rsd,
    input logic rtv, input int rtt, input int rtd);
    rec_t r;
    logic [31:0] ins;
    ins      = dp.ifetch_intruction;
    r.ren    = ren;
    r.jmp    = ren && (kind == K_J);
    r.en_i   = ren && (kind == K_INT);
    r.en_l   = ren && (kind == K_LS);
    r.en_m   = ren && (kind == K_MUL);
    r.op     = op;
    r.rd_tag = TAG_W'(rdt);
    r.rs_v   = rsv;
    r.rs_t   = TAG_W'(rst_);
    r.rs_d   = DATA_W'(rsd);
    r.rt_v   = rtv;
    r.rt_t   = TAG_W'(rtt);
    r.rt_d   = DATA_W'(rtd);
    r.sh     = ins[10:6];
    r.imm    = ins[15:0];
    r.ja     = {dp.ifetch_pc_4[31:28], ins[25:0], 2'b00};
    return r;
  endfunction

  function automatic logic [REC_W-1:0] obs();
    rec_t r;
    r.ren    = dp.Dispatch_ren;
    r.jmp    = dp.Dispatch_jmp;
    r.en_i   = dp.dispatch_en_integer;
    r.en_l   = dp.dispatch_en_ld_st;
    r.en_m   = dp.dispatch_en_mul;
    r.op     = dp.dispatch_opcode;
    r.rd_tag = dp.dispatch_rd_tag;
    r.rs_v   = dp.dispatch_rs_data_valid;
    r.rs_t   = dp.dispatch_rs_tag;
    r.rs_d   = dp.dispatch_rs_data;
    r.rt_v   = dp.dispatch_rt_data_valid;
    r.rt_t   = dp.dispatch_rt_tag;
    r.rt_d   = dp.dispatch_rt_data;
    r.sh     = dp.dispatch_shfamt;
    r.imm    = dp.dispatch_imm_ld_st;
    r.ja     = dp.Dispatch_jmp_addr;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input logic [31:0] ins);
    dp.ifetch_intruction = ins;
    dp.ifetch_empty      = 1'b0;
  endtask

  task automatic cdb(input logic v, input int tag, input int data);
    dp.cdb_valid = v;
    dp.cdb_tag   = TAG_W'(tag);
    dp.cdb_data  = DATA_W'(data);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    head(32'h0080F820);
    tick();
    exp_q.push_back(mk(1'b0, K_INT, 4'h0, 1, 1, 0, 4, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL reset_add: got=%h exp=%h", got, e); end
    tick();
    head(32'h08000010);
    exp_q.push_back(mk(1'b0, K_J, 4'h0, 1, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL reset_jmp: got=%h exp=%h", got, e); end
    tick();
    rst = 1'b0;
    head(32'h0080F820);
    dp.ifetch_empty = 1'b1;
    exp_q.push_back(mk(1'b0, K_INT, 4'h0, 1, 1, 0, 4, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL empty_hold: got=%h exp=%h", got, e); end
    tick();
  endtask

  task automatic test_add_mul();
    head(32'h0080F820);
    exp_q.push_back(mk(1'b1, K_INT, 4'h0, 1, 1, 0, 4, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL add31: got=%h exp=%h", got, e); end
    tick();
    head(32'h00BF1019);
    exp_q.push_back(mk(1'b1, K_MUL, 4'hA, 2, 1, 0, 5, 0, 1, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL mul_dep: got=%h exp=%h", got, e); end
    tick();
    head(32'h00000000);
    dp.ifetch_empty = 1'b1;
    cdb(1'b1, 1, 32'h55);
    exp_q.push_back(mk(1'b0, K_INT, 4'h5, 3, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL cdb_idle: got=%h exp=%h", got, e); end
    tick();
    cdb(1'b0, 0, 0);
    head(r_type(31, 0, 3, 0, 6'h20));
    exp_q.push_back(mk(1'b1, K_INT, 4'h0, 3, 1, 0, 31, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL read31_cleared: got=%h exp=%h", got, e); end
    tick();
  endtask

  task automatic test_full_stall();
    head(r_type(5, 6, 4, 0, 6'h19));
    dp.issueque_mul_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(1'b0, K_MUL, 4'hA, 4, 1, 0, 5, 1, 0, 6));
      @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
      if (got !== e) begin n_bad++; $display("FAIL mul_full[%0d]: got=%h exp=%h", i, got, e); end
      tick();
    end
    dp.issueque_mul_full = 1'b0;
    exp_q.push_back(mk(1'b1, K_MUL, 4'hA, 4, 1, 0, 5, 1, 0, 6));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL mul_release: got=%h exp=%h", got, e); end
    tick();
    head({6'h23, 5'd2, 5'd7, 16'h0010});
    dp.issueque_full_ld_st = 1'b1;
    dp.issueque_mul_full   = 1'b1;
    exp_q.push_back(mk(1'b0, K_LS, 4'h8, 5, 0, 2, 0, 1, 0, 7));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL lw_full: got=%h exp=%h", got, e); end
    tick();
    dp.issueque_full_ld_st = 1'b0;
    exp_q.push_back(mk(1'b1, K_LS, 4'h8, 5, 0, 2, 0, 1, 0, 7));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL lw_other_full: got=%h exp=%h", got, e); end
    tick();
    dp.issueque_mul_full      = 1'b0;
    dp.issueque_integer_full  = 1'b1;
    head(r_type(0, 0, 12, 0, 6'h20));
    exp_q.push_back(mk(1'b0, K_INT, 4'h0, 6, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL int_full: got=%h exp=%h", got, e); end
    tick();
    dp.issueque_integer_full = 1'b0;
  endtask

  task automatic test_jump();
    dp.ifetch_pc_4 = 32'h00400004;
    head(32'h08000010);
    exp_q.push_back(mk(1'b1, K_J, 4'h0, 6, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL jump: got=%h exp=%h", got, e); end
    if (dp.Dispatch_jmp_addr !== 32'h00000040) begin
      n_bad++; $display("FAIL jump_addr: got=%h exp=00000040", dp.Dispatch_jmp_addr);
    end
    n_total++;
    tick();
    head(r_type(0, 0, 8, 0, 6'h20));
    exp_q.push_back(mk(1'b0, K_INT, 4'h0, 6, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL flush_cycle: got=%h exp=%h", got, e); end
    tick();
    exp_q.push_back(mk(1'b1, K_INT, 4'h0, 6, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL after_flush: got=%h exp=%h", got, e); end
    tick();
    head(32'h3C010000);
    exp_q.push_back(mk(1'b1, K_NONE, 4'h0, 7, 1, 0, 0, 1, 0, 1));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL unsupported: got=%h exp=%h", got, e); end
    tick();
    head(r_type(0, 0, 13, 0, 6'h20));
    exp_q.push_back(mk(1'b1, K_INT, 4'h0, 7, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL no_tag_unsup: got=%h exp=%h", got, e); end
    tick();
  endtask

  task automatic test_reset_in_flush();
    head(32'h08000010);
    exp_q.push_back(mk(1'b1, K_J, 4'h0, 8, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL jump2: got=%h exp=%h", got, e); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    head(r_type(4, 0, 11, 0, 6'h20));
    exp_q.push_back(mk(1'b1, K_INT, 4'h0, 1, 1, 0, 4, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL reset_flush: got=%h exp=%h", got, e); end
    tick();
  endtask

  task automatic test_tag_exhaust();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    head(32'hAC000000);
    for (int i = 1; i <= 31; i++) begin
      exp_q.push_back(mk(1'b1, K_LS, 4'h9, i, 1, 0, 0, 1, 0, 0));
      @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
      if (got !== e) begin n_bad++; $display("FAIL exhaust[%0d]: got=%h exp=%h", i, got, e); end
      tick();
    end
    exp_q.push_back(mk(1'b0, K_LS, 4'h9, 1, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL pool_empty: got=%h exp=%h", got, e); end
    tick();
    cdb(1'b1, 1, 0);
    exp_q.push_back(mk(1'b0, K_LS, 4'h9, 1, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL free_same_cycle: got=%h exp=%h", got, e); end
    tick();
    cdb(1'b0, 0, 0);
    exp_q.push_back(mk(1'b1, K_LS, 4'h9, 1, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL wrap_tag1: got=%h exp=%h", got, e); end
    tick();
    exp_q.push_back(mk(1'b0, K_LS, 4'h9, 2, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL tag2_busy: got=%h exp=%h", got, e); end
    tick();
  endtask

  task automatic test_cdb_forward();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    head(32'h0080F820);
    exp_q.push_back(mk(1'b1, K_INT, 4'h0, 1, 1, 0, 4, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL fwd_add31: got=%h exp=%h", got, e); end
    tick();
    head(32'h00BF1019);
    cdb(1'b1, 1, 32'h10);
`ifdef CDB_BYPASS_EN
    exp_q.push_back(mk(1'b1, K_MUL, 4'hA, 2, 1, 0, 5, 1, 0, 32'h10));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL fwd_bypass: got=%h exp=%h", got, e); end
    tick();
    cdb(1'b0, 0, 0);
`else
    exp_q.push_back(mk(1'b0, K_MUL, 4'hA, 2, 1, 0, 5, 0, 1, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL fwd_stall: got=%h exp=%h", got, e); end
    tick();
    cdb(1'b0, 0, 0);
    exp_q.push_back(mk(1'b1, K_MUL, 4'hA, 2, 1, 0, 5, 1, 0, 31));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL fwd_after_stall: got=%h exp=%h", got, e); end
    tick();
`endif
    head(r_type(0, 0, 9, 0, 6'h20));
    exp_q.push_back(mk(1'b1, K_INT, 4'h0, 3, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL wr9_first: got=%h exp=%h", got, e); end
    tick();
    cdb(1'b1, 3, 32'h77);
    exp_q.push_back(mk(1'b1, K_INT, 4'h0, 4, 1, 0, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL wr9_vs_cdb: got=%h exp=%h", got, e); end
    tick();
    cdb(1'b0, 0, 0);
    head(r_type(9, 0, 10, 0, 6'h20));
    exp_q.push_back(mk(1'b1, K_INT, 4'h0, 5, 0, 4, 0, 1, 0, 0));
    @(negedge clk); got = obs(); e = exp_q.pop_front(); n_total++;
    if (got !== e) begin n_bad++; $display("FAIL write_wins: got=%h exp=%h", got, e); end
    tick();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst                      = 1'b1;
    dp.ifetch_pc_4           = 32'h00400004;
    dp.ifetch_intruction     = 32'h0;
    dp.ifetch_empty          = 1'b1;
    dp.cdb_valid             = 1'b0;
    dp.cdb_tag               = '0;
    dp.cdb_data              = '0;
    dp.issueque_integer_full = 1'b0;
    dp.issueque_full_ld_st   = 1'b0;
    dp.issueque_mul_full     = 1'b0;
    test_reset();
    test_add_mul();
    test_full_stall();
    test_jump();
    test_reset_in_flush();
    test_tag_exhaust();
    test_cdb_forward();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got=%0d exp=0", exp_q.size());
    end
    n_total++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
